// File: rtl/bram_arb_pkg.sv
// ============================================================================
// Module : bram_arb_pkg
// Brief  : Shared owner/requester encodings for the BRAM port arbiters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  function automatic logic owner_to_id(input owner_e own);
    return (own == OWN_M1) ? ID_M1 : ID_M0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_rd_tag_pipe.sv
// ============================================================================
// Module : bram_rd_tag_pipe
// Brief  : DEPTH-stage {valid, id} delay line that follows reads through the BRAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bram_rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  input  logic in_id_i,
  output logic out_valid_o,
  output logic out_id_o
);

  rd_tag_t [DEPTH-1:0] stage_q;

  // Clearing on reset drops any read still in flight, so no strobe follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= '{valid: in_valid_i, id: in_id_i};
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid_o = stage_q[DEPTH-1].valid;
  assign out_id_o    = stage_q[DEPTH-1].id;

endmodule

`default_nettype wire

// File: rtl/bram_rr_arbiter.sv
// ============================================================================
// Module : bram_rr_arbiter
// Brief  : Burst-limited round-robin arbiter sharing one BRAM port between m0/m1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_data_in,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_data_out,
  output logic                  m0_valid,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_data_in,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_data_out,
  output logic                  m1_valid,
  output logic                  bram_en,
  output logic                  bram_wr,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out
);

  localparam int               CNT_W       = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] C_BURST_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  owner_e           owner_q, owner_d;
  owner_e           last_q, last_d;
  owner_e           winner;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             tag_valid;
  logic             tag_id;

  // Reset gating keeps every grant and BRAM strobe low while rst_n is asserted.
  always_comb begin
    winner = OWN_NONE;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        if ((owner_q != OWN_NONE) && (burst_cnt_q < C_BURST_MAX)) begin
          winner = owner_q;
        end else begin
          winner = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
        end
      end else if (m0_req) begin
        winner = OWN_M0;
      end else if (m1_req) begin
        winner = OWN_M1;
      end
    end
  end

  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (winner == OWN_NONE) begin
      owner_d     = OWN_NONE;
      burst_cnt_d = '0;
    end else begin
      last_d = winner;
      if (winner == owner_q) begin
        burst_cnt_d = (burst_cnt_q < C_BURST_MAX) ? burst_cnt_q + C_ONE : C_BURST_MAX;
      end else begin
        owner_d     = winner;
        burst_cnt_d = C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      last_q      <= OWN_M1;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign m0_gnt  = (winner == OWN_M0);
  assign m1_gnt  = (winner == OWN_M1);
  assign bram_en = (winner != OWN_NONE);

  always_comb begin
    bram_wr      = 1'b0;
    bram_addr    = '0;
    bram_data_in = '0;
    if (winner == OWN_M0) begin
      bram_wr      = m0_wr;
      bram_addr    = m0_addr;
      bram_data_in = m0_data_in;
    end else if (winner == OWN_M1) begin
      bram_wr      = m1_wr;
      bram_addr    = m1_addr;
      bram_data_in = m1_data_in;
    end
  end

  bram_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bram_en && !bram_wr),
    .in_id_i     (owner_to_id(winner)),
    .out_valid_o (tag_valid),
    .out_id_o    (tag_id)
  );

  assign m0_valid    = tag_valid && (tag_id == ID_M0);
  assign m1_valid    = tag_valid && (tag_id == ID_M1);
  assign m0_data_out = bram_data_out;
  assign m1_data_out = bram_data_out;

endmodule

`default_nettype wire

// File: tb/tb_bram_rr_arbiter.sv
// ============================================================================
// Module : tb_bram_rr_arbiter
// Brief  : Directed self-checking bench; three DUTs at read latencies 1, 2 and 3.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bram_rr_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // u1: RD_LATENCY=1
  logic          u1_m0_req, u1_m0_wr, u1_m0_gnt, u1_m0_valid;
  logic          u1_m1_req, u1_m1_wr, u1_m1_gnt, u1_m1_valid;
  logic [AW-1:0] u1_m0_addr, u1_m1_addr, u1_bram_addr;
  logic [DW-1:0] u1_m0_din, u1_m1_din, u1_m0_dout, u1_m1_dout;
  logic          u1_bram_en, u1_bram_wr;
  logic [DW-1:0] u1_bram_din, u1_bram_dout;
  logic [DW-1:0] mem1 [0:15];

  // u2: RD_LATENCY=2
  logic          u2_m0_req, u2_m0_wr, u2_m0_gnt, u2_m0_valid;
  logic          u2_m1_req, u2_m1_wr, u2_m1_gnt, u2_m1_valid;
  logic [AW-1:0] u2_m0_addr, u2_m1_addr, u2_bram_addr;
  logic [DW-1:0] u2_m0_din, u2_m1_din, u2_m0_dout, u2_m1_dout;
  logic          u2_bram_en, u2_bram_wr;
  logic [DW-1:0] u2_bram_din;
  logic [DW-1:0] u2_bram_dout;

  // u3: RD_LATENCY=3
  logic          u3_m0_req, u3_m0_wr, u3_m0_gnt, u3_m0_valid;
  logic          u3_m1_req, u3_m1_wr, u3_m1_gnt, u3_m1_valid;
  logic [AW-1:0] u3_m0_addr, u3_m1_addr, u3_bram_addr;
  logic [DW-1:0] u3_m0_din, u3_m1_din, u3_m0_dout, u3_m1_dout;
  logic          u3_bram_en, u3_bram_wr;
  logic [DW-1:0] u3_bram_din;
  logic [DW-1:0] mem3 [0:15];
  logic [DW-1:0] rd3 [0:2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .BURST_MAX(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(u1_m0_req), .m0_wr(u1_m0_wr), .m0_addr(u1_m0_addr), .m0_data_in(u1_m0_din),
    .m0_gnt(u1_m0_gnt), .m0_data_out(u1_m0_dout), .m0_valid(u1_m0_valid),
    .m1_req(u1_m1_req), .m1_wr(u1_m1_wr), .m1_addr(u1_m1_addr), .m1_data_in(u1_m1_din),
    .m1_gnt(u1_m1_gnt), .m1_data_out(u1_m1_dout), .m1_valid(u1_m1_valid),
    .bram_en(u1_bram_en), .bram_wr(u1_bram_wr), .bram_addr(u1_bram_addr),
    .bram_data_in(u1_bram_din), .bram_data_out(u1_bram_dout)
  );

  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .BURST_MAX(4)) u2 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(u2_m0_req), .m0_wr(u2_m0_wr), .m0_addr(u2_m0_addr), .m0_data_in(u2_m0_din),
    .m0_gnt(u2_m0_gnt), .m0_data_out(u2_m0_dout), .m0_valid(u2_m0_valid),
    .m1_req(u2_m1_req), .m1_wr(u2_m1_wr), .m1_addr(u2_m1_addr), .m1_data_in(u2_m1_din),
    .m1_gnt(u2_m1_gnt), .m1_data_out(u2_m1_dout), .m1_valid(u2_m1_valid),
    .bram_en(u2_bram_en), .bram_wr(u2_bram_wr), .bram_addr(u2_bram_addr),
    .bram_data_in(u2_bram_din), .bram_data_out(u2_bram_dout)
  );

  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3), .BURST_MAX(4)) u3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(u3_m0_req), .m0_wr(u3_m0_wr), .m0_addr(u3_m0_addr), .m0_data_in(u3_m0_din),
    .m0_gnt(u3_m0_gnt), .m0_data_out(u3_m0_dout), .m0_valid(u3_m0_valid),
    .m1_req(u3_m1_req), .m1_wr(u3_m1_wr), .m1_addr(u3_m1_addr), .m1_data_in(u3_m1_din),
    .m1_gnt(u3_m1_gnt), .m1_data_out(u3_m1_dout), .m1_valid(u3_m1_valid),
    .bram_en(u3_bram_en), .bram_wr(u3_bram_wr), .bram_addr(u3_bram_addr),
    .bram_data_in(u3_bram_din), .bram_data_out(rd3[2])
  );

  assign u2_bram_dout = '0;

  // Behavioural BRAMs: u1 one-cycle read, u3 three-cycle read pipeline.
  always @(posedge clk) begin
    if (u1_bram_en && u1_bram_wr) mem1[u1_bram_addr] <= u1_bram_din;
    if (u1_bram_en && !u1_bram_wr) u1_bram_dout <= mem1[u1_bram_addr];
  end

  always @(posedge clk) begin
    if (u3_bram_en && u3_bram_wr) mem3[u3_bram_addr] <= u3_bram_din;
    rd3[0] <= mem3[u3_bram_addr];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] exp_d;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    {u1_m0_req, u1_m0_wr, u1_m0_addr, u1_m0_din} = '0;
    {u1_m1_req, u1_m1_wr, u1_m1_addr, u1_m1_din} = '0;
    {u2_m0_req, u2_m0_wr, u2_m0_addr, u2_m0_din} = '0;
    {u2_m1_req, u2_m1_wr, u2_m1_addr, u2_m1_din} = '0;
    {u3_m0_req, u3_m0_wr, u3_m0_addr, u3_m0_din} = '0;
    {u3_m1_req, u3_m1_wr, u3_m1_addr, u3_m1_din} = '0;

    // Reset state with both requests already raised.
    u1_m0_req = 1'b1; u1_m0_wr = 1'b1;
    u1_m1_req = 1'b1; u1_m1_wr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_m0_gnt", 32'(u1_m0_gnt), 0);
    check("rst_m1_gnt", 32'(u1_m1_gnt), 0);
    check("rst_bram_en", 32'(u1_bram_en), 0);
    check("rst_bram_wr", 32'(u1_bram_wr), 0);
    check("rst_m0_valid", 32'(u1_m0_valid), 0);

    // Both held from release: blocks of four grants, m0 first.
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("burst_m0_gnt_c%0d", c), 32'(u1_m0_gnt), 32'(((c / 4) % 2) == 0));
      check($sformatf("burst_m1_gnt_c%0d", c), 32'(u1_m1_gnt), 32'(((c / 4) % 2) == 1));
      @(negedge clk);
    end

    // Idle, then m0 alone for 10 cycles, then m1 joins with burst saturated.
    u1_m0_req = 1'b0; u1_m1_req = 1'b0;
    #1;
    check("idle_bram_en", 32'(u1_bram_en), 0);
    @(negedge clk);
    u1_m0_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("lone_m0_gnt_c%0d", c), 32'(u1_m0_gnt), 1);
      @(negedge clk);
    end
    u1_m1_req = 1'b1;
    #1;
    check("sat_m1_gnt", 32'(u1_m1_gnt), 1);
    check("sat_m0_gnt", 32'(u1_m0_gnt), 0);
    @(negedge clk);

    // m0 served last, idle, then both: m1 wins first.
    u1_m1_req = 1'b0;
    #1;
    check("last_m0_gnt", 32'(u1_m0_gnt), 1);
    @(negedge clk);
    u1_m0_req = 1'b0;
    @(negedge clk);
    u1_m0_req = 1'b1; u1_m1_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("alt_m1_gnt_c%0d", c), 32'(u1_m1_gnt), 32'(c < 4));
      check($sformatf("alt_m0_gnt_c%0d", c), 32'(u1_m0_gnt), 32'(c >= 4));
      @(negedge clk);
    end

    // m0 writes 0xA5 to addr 5 then reads it back.
    u1_m1_req = 1'b0;
    u1_m0_req = 1'b1; u1_m0_wr = 1'b1; u1_m0_addr = 4'd5; u1_m0_din = 8'hA5;
    #1;
    check("wr_m0_gnt", 32'(u1_m0_gnt), 1);
    check("wr_bram_wr", 32'(u1_bram_wr), 1);
    check("wr_bram_addr", 32'(u1_bram_addr), 5);
    check("wr_bram_din", 32'(u1_bram_din), 32'hA5);
    @(posedge clk);
    #1;
    check("wr_m0_valid", 32'(u1_m0_valid), 0);
    @(negedge clk);
    u1_m0_wr = 1'b0; u1_m0_din = 8'h00;
    #1;
    check("rd_m0_gnt", 32'(u1_m0_gnt), 1);
    check("rd_bram_wr", 32'(u1_bram_wr), 0);
    @(posedge clk);
    #1;
    check("rd_m0_valid", 32'(u1_m0_valid), 1);
    check("rd_m0_data", 32'(u1_m0_dout), 32'hA5);
    check("rd_m1_valid", 32'(u1_m1_valid), 0);
    @(negedge clk);
    u1_m0_req = 1'b0;
    @(posedge clk);
    #1;
    check("rd_m0_valid_end", 32'(u1_m0_valid), 0);

    // Latency 3: preload addrs 1..4, then alternate m0/m1 reads.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      u3_m0_req = 1'b1; u3_m0_wr = 1'b1; u3_m0_addr = 4'(i); u3_m0_din = 8'(17 * i);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      u3_m0_req = 1'b0; u3_m0_wr = 1'b0; u3_m1_req = 1'b0; u3_m1_wr = 1'b0;
      if (k < 4) begin
        if (k % 2 == 0) begin
          u3_m0_req = 1'b1; u3_m0_addr = 4'(k + 1);
        end else begin
          u3_m1_req = 1'b1; u3_m1_addr = 4'(k + 1);
        end
        #1;
        check($sformatf("l3_gnt_k%0d", k), 32'((k % 2 == 0) ? u3_m0_gnt : u3_m1_gnt), 1);
        check($sformatf("l3_addr_k%0d", k), 32'(u3_bram_addr), 32'(k + 1));
      end
      @(posedge clk);
      #1;
      check($sformatf("l3_m0_valid_k%0d", k), 32'(u3_m0_valid), 32'(k == 2 || k == 4));
      check($sformatf("l3_m1_valid_k%0d", k), 32'(u3_m1_valid), 32'(k == 3 || k == 5));
      if (k >= 2 && k <= 5) begin
        exp_d = 8'(17 * (k - 1));
        check($sformatf("l3_data_k%0d", k),
              32'((k % 2 == 0) ? u3_m0_dout : u3_m1_dout), 32'(exp_d));
      end
    end

    // Latency 2: reset right after an m1 read grant discards that read.
    @(negedge clk);
    u2_m1_req = 1'b1; u2_m1_wr = 1'b0; u2_m1_addr = 4'd7;
    #1;
    check("r6_m1_gnt", 32'(u2_m1_gnt), 1);
    @(posedge clk);
    #1;
    check("r6_m1_valid_e0", 32'(u2_m1_valid), 0);
    @(negedge clk);
    rst_n = 1'b0;
    u2_m0_req = 1'b1; u2_m0_wr = 1'b1; u2_m0_addr = 4'd3;
    #1;
    check("r6_rst_m0_gnt", 32'(u2_m0_gnt), 0);
    check("r6_rst_m1_gnt", 32'(u2_m1_gnt), 0);
    check("r6_rst_bram_en", 32'(u2_bram_en), 0);
    check("r6_rst_bram_wr", 32'(u2_bram_wr), 0);
    check("r6_rst_m1_valid", 32'(u2_m1_valid), 0);
    @(posedge clk);
    #1;
    check("r6_m1_valid_e1", 32'(u2_m1_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("r6_post_m0_gnt", 32'(u2_m0_gnt), 1);
    check("r6_post_m1_gnt", 32'(u2_m1_gnt), 0);
    @(posedge clk);
    #1;
    check("r6_m1_valid_e2", 32'(u2_m1_valid), 0);
    @(negedge clk);
    u2_m0_req = 1'b0; u2_m1_req = 1'b0;
    @(posedge clk);
    #1;
    check("r6_m1_valid_e3", 32'(u2_m1_valid), 0);
    check("r6_m0_valid_e3", 32'(u2_m0_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Round-robin arbiter that shares one synchronous BRAM port between two requesters (m0, m1).
- Sits in front of port A of the shared-memory BRAM primitives; serves at most one access per cycle.
- Limits each owner to BURST_MAX consecutive grants while the other requester waits.
- Tracks in-flight reads so each requester gets its own read-valid strobe after the BRAM latency.

Parameters:
DATA_WIDTH, 32, width of the BRAM data port
ADDR_WIDTH, 10, width of the BRAM address
RD_LATENCY, 1, BRAM read latency in cycles (1..4)
BURST_MAX, 4, max consecutive grants to one owner while the other requests (>=1)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req / m1_req  in  1  access request, held until granted
m0_wr / m1_wr  in  1  1=write, 0=read
m0_addr / m1_addr  in  ADDR_WIDTH  access address
m0_data_in / m1_data_in  in  DATA_WIDTH  write data
m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational)
m0_data_out / m1_data_out  out  DATA_WIDTH  read data (bram_data_out broadcast)
m0_valid / m1_valid  out  1  one-cycle strobe: data_out holds this requester's read
bram_en  out  1  BRAM access enable
bram_wr  out  1  BRAM write enable
bram_addr  out  ADDR_WIDTH  BRAM address
bram_data_in  out  DATA_WIDTH  BRAM write data
bram_data_out  in  DATA_WIDTH  BRAM read data, RD_LATENCY after bram_en

Behaviour:
- Registered state:
  - owner in {NONE, M0, M1}
  - last (last requester served; reset value M1, so m0 wins first contention)
  - burst_cnt, width clog2(BURST_MAX+1)
  - read-tag pipeline, RD_LATENCY stages of {valid, id}
- Reset (async assert): owner=NONE, burst_cnt=0, last=M1, pipeline cleared.
  - While rst_n=0: all gnt, bram_en, bram_wr and valid are 0.
  - Reads in flight at reset are discarded; no valid is issued for them.
- Winner, combinational each cycle:
  - neither req: none.
  - exactly one req: that requester.
  - both req, owner=x and burst_cnt<BURST_MAX: x.
  - both req otherwise: the requester != last.
- Datapath outputs:
  - mX_gnt = (winner==X).
  - bram_en = (winner!=none); bram_wr/addr/data_in are muxed from the winner.
  - When there is no winner, bram_wr=0 and addr/data are don't-care (drive 0).
- Clock-edge state updates:
  - winner==owner: burst_cnt = min(burst_cnt+1, BURST_MAX).
  - winner new: owner=winner, burst_cnt=1.
  - no winner: owner=NONE, burst_cnt=0.
  - last=winner whenever a winner exists.
- Burst saturation: a lone requester is granted every cycle indefinitely, with burst_cnt saturated. When the other requester then raises req, it wins on that first cycle if burst_cnt==BURST_MAX.
- Read tracking:
  - A granted read pushes {1, id} into the pipeline; writes push {0, -}.
  - mX_valid=1 when the tail stage is valid with id==X.
  - Back-to-back reads from alternating requesters are supported at full rate.
- Data out: m0_data_out and m1_data_out are both wired to bram_data_out (no register); consumers qualify with valid.
- Write-then-read on the same address in consecutive cycles: the read returns the new data (BRAM write-first behaviour is assumed by the caller's BRAM choice, not enforced here).
- Requester rule: a requester must not change wr/addr/data while req=1 and gnt=0. The arbiter does not check this.

Decomposition:
- Shared package bram_arb_pkg holds:
  - owner encodings OWN_NONE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2
  - requester id encoding ID_M0=1'b0, ID_M1=1'b1
- Sub-module bram_rd_tag_pipe: RD_LATENCY-deep {valid, id} delay line with async active-low clear. It is reused by later multi-port arbiters.

Test Plan:
1. m0 writes 0xA5 to addr 5, then reads addr 5 (RD_LATENCY=1) -> m0_gnt both cycles; m0_valid pulses 1 cycle after the read with m0_data_out=0xA5; m1_valid stays 0.
2. m0_req and m1_req held high from reset release, BURST_MAX=4 -> m0 granted cycles 0-3, m1 cycles 4-7, m0 cycles 8-11; exactly one gnt per cycle.
3. m0 alone for 10 cycles, then m1 raises req -> m0 granted all 10 cycles; m1 granted on its first request cycle (burst_cnt saturated at 4).
4. Idle cycle after m0 was last served, then both request -> m1 granted first (last=M0); then alternation continues per BURST_MAX.
5. RD_LATENCY=3, alternating m0/m1 reads of addrs 1, 2, 3, 4 holding 0x11..0x44 -> valids at +3 cycles in order m0, m1, m0, m1 with data 0x11, 0x22, 0x33, 0x44.
6. rst_n pulsed low 1 cycle after an m1 read grant (RD_LATENCY=2) -> no m1_valid ever for that read; all gnt 0 during reset; after release, simultaneous requests grant m0 first.
